// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_queue                                            |
// | Description : Instruction-fetch front end. Issues sequential word    |
// |               addresses to a fixed-latency read port, tracks the     |
// |               in-flight reads in a tagged shift register and buffers |
// |               the returns in a circular prefetch queue that feeds    |
// |               decode in program order over a valid/ready handshake.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          redirect_tgt,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [INSTR_W-1:0]         mem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IF_W  = $clog2(MEM_LAT + 1);
  localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [MEM_LAT-1:0] sr_valid;
  logic [ADDR_W-1:0]  sr_pc [MEM_LAT];
  logic [INSTR_W-1:0] entry_instr [DEPTH];
  logic [ADDR_W-1:0]  entry_pc [DEPTH];

  logic [IF_W-1:0]    inflight;
  logic               issue;
  logic               push;
  logic               pop;

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Count outstanding reads and decide whether a new fetch has a slot reserved.
  // A pop in the same cycle is deliberately not credited, so count plus
  // inflight never exceeds DEPTH and the queue cannot overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + IF_W'(sr_valid[i]);
    end
    issue = !rst && !flush && !halt &&
            ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));
    push  = !rst && !flush && sr_valid[MEM_LAT-1];
    pop   = !rst && !flush && out_valid && out_ready;
  end

  // Fetch PC: reset, redirect on flush, otherwise advance by one word per issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (flush) begin
      fetch_pc <= redirect_tgt;
    end else if (issue) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // In-flight valid tags; clearing them on flush drops the stale returns.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sr_valid <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        sr_valid[i] <= sr_valid[i-1];
      end
      sr_valid[0] <= issue;
    end
  end

  // In-flight PCs travel alongside the tags; only the tags need reset.
  always_ff @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      sr_pc[i] <= sr_pc[i-1];
    end
    sr_pc[0] <= fetch_pc;
  end

  // Queue storage: the returning word and its PC land at tail.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_instr[tail] <= mem_data;
      entry_pc[tail]    <= sr_pc[MEM_LAT-1];
    end
  end

  // Queue pointers and occupancy; flush empties the queue and beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A push without a pop must never find the queue already full.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      assert (count != CNT_W'(DEPTH));
    end
  end

  // Head presentation; zeroed while empty so the reset view is all zeros.
  always_comb begin
    mem_addr  = fetch_pc;
    occupancy = count;
    out_valid = (count != '0);
    out_instr = out_valid ? entry_instr[head] : '0;
    out_pc    = out_valid ? entry_pc[head] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                         |
// | Description : Directed self-checking bench for fetch_queue. DUT a    |
// |               uses MEM_LAT=1 / RESET_PC=0, DUT b uses MEM_LAT=3 /    |
// |               RESET_PC=0xFFFFFFF8. Memory returns addr+0x100.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a signals
  logic        rst_a = 1'b1, halt_a = 1'b0, flush_a = 1'b0, ready_a = 1'b0;
  logic [31:0] tgt_a = '0;
  logic [31:0] addr_a, data_a, instr_a, pc_a;
  logic        valid_a;
  logic [2:0]  occ_a;

  // DUT b signals
  logic        rst_b = 1'b1, halt_b = 1'b0, flush_b = 1'b0, ready_b = 1'b0;
  logic [31:0] tgt_b = '0;
  logic [31:0] addr_b, data_b, instr_b, pc_b;
  logic        valid_b;
  logic [2:0]  occ_b;

  // Fixed-latency memory models: word at addr is addr + 0x100
  logic [31:0] a_d1 = '0;
  logic [31:0] b_d1 = '0, b_d2 = '0, b_d3 = '0;
  always @(posedge clk) begin
    a_d1 <= addr_a;
    b_d1 <= addr_b;
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign data_a = a_d1 + 32'h100;
  assign data_b = b_d3 + 32'h100;

  fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .MEM_LAT(1), .RESET_PC(32'h0)
  ) u_a (
    .clk(clk), .rst(rst_a), .halt(halt_a), .flush(flush_a),
    .redirect_tgt(tgt_a), .mem_addr(addr_a), .mem_data(data_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_instr(instr_a),
    .out_pc(pc_a), .occupancy(occ_a)
  );

  fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .MEM_LAT(3), .RESET_PC(32'hFFFF_FFF8)
  ) u_b (
    .clk(clk), .rst(rst_b), .halt(halt_b), .flush(flush_b),
    .redirect_tgt(tgt_b), .mem_addr(addr_b), .mem_data(data_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_instr(instr_b),
    .out_pc(pc_b), .occupancy(occ_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sampling and driving happen 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 32'hFFFF_FFF8;
    wrap_seq[1] = 32'hFFFF_FFFC;
    wrap_seq[2] = 32'h0000_0000;
    wrap_seq[3] = 32'h0000_0004;

    step();
    step();

    // ---------------- Test 1: basic streaming, MEM_LAT=1 ----------------
    rst_a   = 1'b0;
    ready_a = 1'b1;
    chk("t1_rst_valid", valid_a, 0);
    chk("t1_rst_instr", instr_a, 0);
    chk("t1_rst_pc",    pc_a,    0);
    chk("t1_rst_occ",   occ_a,   0);
    chk("t1_c0_addr",   addr_a,  0);
    step();
    chk("t1_c1_addr",  addr_a,  32'h4);
    chk("t1_c1_valid", valid_a, 0);
    step();
    chk("t1_c2_valid", valid_a, 1);
    chk("t1_c2_pc",    pc_a,    32'h0);
    chk("t1_c2_instr", instr_a, 32'h100);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t1_stream_valid", valid_a, 1);
      chk("t1_stream_pc",    pc_a,    32'(4 * k));
      chk("t1_stream_instr", instr_a, 32'(32'h100 + 4 * k));
    end

    // ---------------- Test 2: backpressure -----------------------------
    ready_a = 1'b0;
    rst_a   = 1'b1;
    step();
    rst_a = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk("t2_addr", addr_a, (c < 4) ? 32'(4 * c) : 32'h10);
      step();
    end
    chk("t2_full_addr",  addr_a,  32'h10);
    chk("t2_full_occ",   occ_a,   4);
    chk("t2_full_valid", valid_a, 1);
    chk("t2_full_pc",    pc_a,    32'h0);
    chk("t2_full_instr", instr_a, 32'h100);
    ready_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_drain_valid", valid_a, 1);
      chk("t2_drain_pc",    pc_a,    32'(4 * k));
    end

    // ---------------- Test 4: halt after two issues ---------------------
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    step();
    step();
    halt_a = 1'b1;
    chk("t4_c2_addr", addr_a, 32'h8);
    chk("t4_c2_pc",   pc_a,   32'h0);
    chk("t4_c2_valid", valid_a, 1);
    step();
    chk("t4_c3_pc",    pc_a,    32'h4);
    chk("t4_c3_valid", valid_a, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_idle_valid", valid_a, 0);
      chk("t4_idle_addr",  addr_a,  32'h8);
    end
    halt_a = 1'b0;

    // ---------------- Test 6: flush vs pop, rst vs flush ----------------
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    step();
    step();
    step();
    chk("t6_pre_valid", valid_a, 1);
    chk("t6_pre_occ",   occ_a,   1);
    flush_a = 1'b1;
    tgt_a   = 32'h80;
    step();
    flush_a = 1'b0;
    chk("t6_flush_occ",   occ_a,   0);
    chk("t6_flush_valid", valid_a, 0);
    chk("t6_flush_addr",  addr_a,  32'h80);
    step();
    step();
    step();
    rst_a   = 1'b1;
    flush_a = 1'b1;
    step();
    rst_a   = 1'b0;
    flush_a = 1'b0;
    chk("t6_rst_addr", addr_a, 32'h0);
    chk("t6_rst_occ",  occ_a,  0);

    // ---------------- Test 5: address wrap, MEM_LAT=3 -------------------
    ready_b = 1'b1;
    rst_b   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t5_issue_addr", addr_b, wrap_seq[c]);
      chk("t5_issue_valid", valid_b, 0);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      chk("t5_out_valid", valid_b, 1);
      chk("t5_out_pc",    pc_b,    wrap_seq[c]);
      chk("t5_out_instr", instr_b, wrap_seq[c] + 32'h100);
      step();
    end

    // ---------------- Test 3: flush with reads in flight ----------------
    ready_b = 1'b0;
    rst_b   = 1'b1;
    step();
    rst_b = 1'b0;
    step();
    step();
    step();
    step();
    chk("t3_pre_occ", occ_b, 1);
    chk("t3_pre_pc",  pc_b,  32'hFFFF_FFF8);
    flush_b = 1'b1;
    tgt_b   = 32'h400;
    step();
    flush_b = 1'b0;
    chk("t3_post_occ",   occ_b,   0);
    chk("t3_post_addr",  addr_b,  32'h400);
    chk("t3_post_valid", valid_b, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_gap_valid", valid_b, 0);
      chk("t3_gap_occ",   occ_b,   0);
    end
    step();
    chk("t3_first_valid", valid_b, 1);
    chk("t3_first_pc",    pc_b,    32'h400);
    chk("t3_first_instr", instr_b, 32'h500);
    ready_b = 1'b1;
    step();
    chk("t3_next_valid", valid_b, 1);
    chk("t3_next_pc",    pc_b,    32'h404);
    chk("t3_next_instr", instr_b, 32'h504);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
